// File: rtl/xd_pkg.sv
// xd_pkg: state encoding and shared synchronizer depth for the clock-crossing blocks
package xd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, WAIT = 2'd2} xd_state_e;
  localparam int XD_SYNC_STAGES = 2;
endpackage

// File: rtl/xd_sync_bit.sv
// xd_sync_bit: N-stage single-bit synchronizer with synchronous active-low reset
module xd_sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  always_ff @(posedge clk)
    if (!rst_n) sr <= '0;
    else sr <= {sr[N-2:0], d};
  assign q = sr[N-1];
endmodule

// File: rtl/xd_hs_tx.sv
// xd_hs_tx: transmit end of a toggle req/ack handshake carrying a WIDTH-bit word across clocks
// Optional abort on missing ack via XD_HS_TX_TIMEOUT_EN.
module xd_hs_tx
  import xd_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = XD_SYNC_STAGES,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] xd_data,
  output logic             req_tgl,
  input  logic             ack_tgl,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);
  xd_state_e state, state_d;
  logic ack_s, ack_prev, ack_edge, accept, to_hit;
  xd_sync_bit #(.N(SYNC_STAGES)) u_ack_sync (.clk(clk), .rst_n(rst_n), .d(ack_tgl), .q(ack_s));
  assign in_ready = state == IDLE;
  assign busy     = !in_ready;
  assign ack_edge = ack_s ^ ack_prev;
  assign accept   = in_valid & in_ready;
  always_comb begin
    state_d = state;
    state_d = (state == IDLE)  ? (accept ? SETUP : IDLE) :
              (state == SETUP) ? WAIT :
              (ack_edge || to_hit) ? IDLE : WAIT;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state    <= IDLE;
      req_tgl  <= 1'b0;
      xd_data  <= '0;
      done     <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      state    <= state_d;
      ack_prev <= ack_s;
      done     <= (state == WAIT) && ack_edge;
      if (accept) xd_data <= in_data;
      if (state == SETUP) req_tgl <= ~req_tgl;
    end
`ifdef XD_HS_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic          terr;
  // ack_edge takes priority: an ack on the last allowed cycle still completes
  assign to_hit = (state == WAIT) && !ack_edge && (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt  <= '0;
      terr <= 1'b0;
    end else begin
      cnt  <= (state == WAIT) ? cnt + CW'(1) : '0;
      terr <= accept ? 1'b0 : (to_hit ? 1'b1 : terr);
    end
  assign timeout_err = terr;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_xd_hs_tx.sv
// tb_xd_hs_tx: directed self-checking bench for xd_hs_tx with a hand-driven ack_tgl
module tb_xd_hs_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] xd_data;
  logic       req_tgl;
  logic       ack_tgl = 1'b0;
  logic       busy, done, timeout_err;
  int         tests = 0;
  int         fails = 0;
  logic       exp_req = 1'b0;
  int         n;

  xd_hs_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .xd_data(xd_data), .req_tgl(req_tgl), .ack_tgl(ack_tgl), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", req_tgl, 0);
    chk("rst_xd_data", xd_data, 0);
    chk("rst_done", done, 0);
    chk("rst_terr", timeout_err, 0);

    // single transfer
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    chk("single_xd_data", xd_data, 8'hA5);
    chk("single_busy", busy, 1);
    chk("single_req_setup", req_tgl, 0);
    tick();
    exp_req = ~exp_req;
    chk("single_req_wait", req_tgl, exp_req);
    tick(); tick();
    chk("single_no_early_done", done, 0);
    ack_tgl = ~ack_tgl;
    wait_done(n);
    chk("single_ack_latency", n, 3);
    chk("single_in_ready_with_done", in_ready, 1);
    tick();
    chk("single_done_one_cycle", done, 0);

    // back-to-back with in_valid held high; in_data moves on while busy
    in_valid = 1'b1; in_data = 8'h01;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("b2b_capture", xd_data, k);
      tick();
      exp_req = ~exp_req;
      chk("b2b_req", req_tgl, exp_req);
      in_data = (k == 3) ? 8'hFF : 8'(k + 1);
      ack_tgl = ~ack_tgl;
      tick();
      chk("b2b_hold_while_busy", xd_data, k);
      tick();
      chk("b2b_no_early_done", done, 0);
      tick();
      chk("b2b_done", done, 1);
      chk("b2b_ready", in_ready, 1);
      chk("b2b_hold_at_done", xd_data, k);
    end
    in_valid = 1'b0;
    tick();
    chk("b2b_no_extra_xfer", in_ready, 1);
    chk("b2b_final_data", xd_data, 8'h03);
    chk("b2b_final_req", req_tgl, exp_req);

    // spurious ack while idle is dropped
    ack_tgl = ~ack_tgl;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("spur_no_done", done, 0);
    end
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    exp_req = ~exp_req;
    chk("spur_req", req_tgl, exp_req);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("spur_waits_for_ack", done | in_ready, 0);
    end
    ack_tgl = ~ack_tgl;
    wait_done(n);
    chk("spur_own_ack", n, 3);
    chk("spur_data", xd_data, 8'h3C);

`ifdef XD_HS_TX_TIMEOUT_EN
    tick();
    in_data = 8'h77; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    exp_req = ~exp_req;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      chk("to_no_done", done, 0);
      tick();
      n++;
    end
    chk("to_wait_cycles", n, 10);
    chk("to_err_set", timeout_err, 1);
    chk("to_no_done_at_abort", done, 0);
    tick();
    chk("to_err_sticky", timeout_err, 1);
    in_data = 8'h88; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("to_err_cleared", timeout_err, 0);
    chk("to_new_data", xd_data, 8'h88);
    tick();
    exp_req = ~exp_req;
    ack_tgl = ~ack_tgl;
    wait_done(n);
    chk("to_recover_done", n, 3);
`endif

    // reset mid-transfer
    tick();
    in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0; ack_tgl = 1'b0;
    tick();
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_req", req_tgl, 0);
    chk("mid_rst_data", xd_data, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle_after", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
